led_sequencer: RTL and testbench

Bus-mapped controller for the 8-bit board LED bank on the processor bus. It holds a pattern and control registers written by the processor. It sequences the pattern through static, blink, rotate and bounce modes at a programmable step rate, and applies 4-bit PWM brightness. It replaces the plain write-latch LED peripheral at the same base address.

---
 rtl/led_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_led_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_sequencer.sv
// Bus-mapped sequencer for the 8-bit LED bank: pattern/control registers, step-rate
// sequencing (static, blink, rotate, bounce) and 4-bit PWM. LED_READBACK_EN adds bus readback.
module led_sequencer #(
  parameter logic [7:0] BASE_ADDR  = 8'hC0,
  parameter int         TICK_DIV   = 100000,
  parameter logic [7:0] PERIOD_RST = 8'd250
) (
  input  logic       CLK,
  input  logic       RESET,
  inout  wire  [7:0] BUS_DATA,
  input  logic [7:0] BUS_ADDR,
  input  logic       BUS_WE,
  output logic [7:0] LED
);

  localparam int TW = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);

  localparam logic [1:0] MODE_STATIC = 2'b00;
  localparam logic [1:0] MODE_BLINK  = 2'b01;
  localparam logic [1:0] MODE_ROTATE = 2'b10;
  localparam logic [1:0] MODE_BOUNCE = 2'b11;

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t state, state_next;

  logic [7:0]    pattern;
  logic          en;
  logic [1:0]    mode;
  logic [7:0]    period;
  logic [3:0]    bright;
  logic [7:0]    frame, frame_step;
  logic          dir_right, dir_step;
  logic          phase;
  logic [TW-1:0] tick_cnt;
  logic [7:0]    step_cnt;
  logic [7:0]    period_last;
  logic [3:0]    pwm_cnt;
  logic [7:0]    offset;
  logic          hit, wr, wr_pattern, run, tick, step, gate;
  logic [7:0]    led_src;

  // Offset subtraction lets the four registers sit at any base without wrap problems.
  assign offset     = BUS_ADDR - BASE_ADDR;
  assign hit        = (offset[7:2] == 6'd0);
  assign wr         = BUS_WE & hit;
  assign wr_pattern = wr & (offset[1:0] == 2'd0);

  assign run         = (state == RUN);
  assign tick        = run && (tick_cnt == TICK_MAX);
  assign period_last = (period == 8'd0) ? 8'd0 : period - 8'd1;
  assign step        = tick && (step_cnt == period_last);
  assign gate        = (bright == 4'hF) | (pwm_cnt < bright);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pattern <= 8'h00;
      en      <= 1'b0;
      mode    <= MODE_STATIC;
      period  <= PERIOD_RST;
      bright  <= 4'hF;
    end else if (wr) begin
      case (offset[1:0])
        2'd0:    pattern <= BUS_DATA;
        2'd1:    begin en <= BUS_DATA[7]; mode <= BUS_DATA[1:0]; end
        2'd2:    period <= BUS_DATA;
        default: bright <= BUS_DATA[3:0];
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    led_src    = pattern;
    case (state)
      IDLE:    if (en) state_next = LOAD;
      LOAD:    state_next = en ? RUN : IDLE;
      default: begin
        if (!en) state_next = IDLE;
        if (mode == MODE_BLINK) led_src = phase ? frame : 8'h00;
        else                    led_src = frame;
      end
    endcase
  end

  // Prescaler and step counter only advance in RUN; LOAD realigns both.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      tick_cnt <= '0;
      step_cnt <= 8'd0;
    end else begin
      if (state == LOAD)  tick_cnt <= '0;
      else if (tick)      tick_cnt <= '0;
      else if (run)       tick_cnt <= tick_cnt + 1'b1;

      if (wr_pattern || state == LOAD) step_cnt <= 8'd0;
      else if (step)                   step_cnt <= 8'd0;
      else if (tick)                   step_cnt <= step_cnt + 8'd1;
    end
  end

  // Bounce flips direction instead of shifting when the leading edge bit is lit.
  always_comb begin
    frame_step = frame;
    dir_step   = dir_right;
    case (mode)
      MODE_ROTATE: frame_step = {frame[6:0], frame[7]};
      MODE_BOUNCE: begin
        if (!dir_right) begin
          if (frame[7]) dir_step   = 1'b1;
          else          frame_step = {frame[6:0], 1'b0};
        end else begin
          if (frame[0]) dir_step   = 1'b0;
          else          frame_step = {1'b0, frame[7:1]};
        end
      end
      default: frame_step = frame;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      frame     <= 8'h00;
      dir_right <= 1'b0;
      phase     <= 1'b0;
    end else if (wr_pattern) begin
      frame     <= BUS_DATA;
      dir_right <= 1'b0;
      phase     <= 1'b1;
    end else if (state == LOAD) begin
      frame     <= pattern;
      dir_right <= 1'b0;
      phase     <= 1'b1;
    end else if (step) begin
      frame     <= frame_step;
      dir_right <= dir_step;
      if (mode == MODE_BLINK) phase <= ~phase;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pwm_cnt <= 4'd0;
      LED     <= 8'h00;
    end else begin
      pwm_cnt <= pwm_cnt + 4'd1;
      LED     <= led_src & {8{gate}};
    end
  end

`ifdef LED_READBACK_EN
  logic [7:0] rd_sel, rd_data;
  logic       rd_valid;

  always_comb begin
    rd_sel = pattern;
    case (offset[1:0])
      2'd0:    rd_sel = pattern;
      2'd1:    rd_sel = {en, 5'b00000, mode};
      2'd2:    rd_sel = period;
      default: rd_sel = {4'h0, bright};
    endcase
  end

  // The selected value is captured on the read edge and driven for one cycle only.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rd_valid <= 1'b0;
      rd_data  <= 8'h00;
    end else begin
      rd_valid <= hit & ~BUS_WE;
      if (hit & ~BUS_WE) rd_data <= rd_sel;
    end
  end

  assign BUS_DATA = rd_valid ? rd_data : 8'hzz;
`else
  assign BUS_DATA = 8'hzz;
`endif

endmodule

// File: tb/tb_led_sequencer.sv
// Scoreboard bench for led_sequencer: expected LED values and step gaps are queued with
// the stimulus and popped as the DUT produces each new output.
module tb_led_sequencer;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [7:0] BUS_ADDR;
  logic       BUS_WE;
  wire  [7:0] BUS_DATA;
  logic [7:0] LED;
  logic [7:0] drvData;
  logic       drvEn;

  int testsRun    = 0;
  int testsFailed = 0;
  logic [31:0] expQ[$];
  int          gapQ[$];

  assign BUS_DATA = drvEn ? drvData : 8'hzz;
  assign (weak0, weak1) BUS_DATA = 8'h00;

  always #5 CLK = ~CLK;

  led_sequencer #(.BASE_ADDR(8'hC0), .TICK_DIV(4), .PERIOD_RST(8'd250)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .BUS_DATA (BUS_DATA),
    .BUS_ADDR (BUS_ADDR),
    .BUS_WE   (BUS_WE),
    .LED      (LED)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic popCompare(input string tag, input logic [31:0] actual);
    logic [31:0] exp;
    exp = (expQ.size() > 0) ? expQ.pop_front() : 32'hDEAD_BEEF;
    checkOutput(tag, actual, exp);
  endtask

  // One bus write: inputs change on the falling edge and are captured on the next rising edge.
  task automatic applyStimulus(input logic [7:0] addr, input logic [7:0] data);
    @(negedge CLK);
    BUS_ADDR = addr;
    drvData  = data;
    drvEn    = 1'b1;
    BUS_WE   = 1'b1;
    @(negedge CLK);
    BUS_ADDR = 8'h00;
    drvEn    = 1'b0;
    BUS_WE   = 1'b0;
  endtask

  task automatic waitChange(input int limit, output int gap, output logic timedOut);
    logic [7:0] prev;
    prev = LED;
    gap  = 0;
    do begin
      @(negedge CLK);
      gap++;
    end while (LED == prev && gap < limit);
    timedOut = (LED == prev);
  endtask

  // Pops n queued LED values; a nonzero queued gap also checks cycles since the previous change.
  task automatic expectChanges(input string tag, input int n, input int limit);
    int   gap, g;
    logic timedOut;
    for (int i = 0; i < n; i++) begin
      waitChange(limit, gap, timedOut);
      if (timedOut) begin
        checkOutput({tag, "_wait"}, gap, limit + 1);
        expQ.delete();
        gapQ.delete();
        return;
      end
      popCompare({tag, "_val"}, LED);
      g = gapQ.pop_front();
      if (g != 0) checkOutput({tag, "_gap"}, gap, g);
    end
  endtask

  task automatic measureBright(input string tag, input logic [3:0] level, input int expOn);
    int onCount;
    applyStimulus(8'hC3, {4'h0, level});
    @(negedge CLK);
    onCount = 0;
    expQ.push_back(expOn);
    for (int i = 0; i < 16; i++) begin
      @(negedge CLK);
      if (LED == 8'hFF) onCount++;
    end
    popCompare(tag, onCount);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   gap;
    logic timedOut;
    RESET    = 1'b1;
    BUS_ADDR = 8'h00;
    BUS_WE   = 1'b0;
    drvEn    = 1'b0;
    drvData  = 8'h00;
    #1;
    checkOutput("rst_led", LED, 8'h00);
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    checkOutput("rst_led_after", LED, 8'h00);
    checkOutput("rst_bus", BUS_DATA, 8'h00);

    // Static idle write: LED follows PATTERN one cycle after the write edge.
    applyStimulus(8'hC0, 8'hA5);
    checkOutput("wr_lat0", LED, 8'h00);
    @(negedge CLK);
    checkOutput("wr_lat1", LED, 8'hA5);
    applyStimulus(8'hC4, 8'h81);
    applyStimulus(8'hBF, 8'h5A);
    repeat (12) @(negedge CLK);
    checkOutput("undecoded", LED, 8'hA5);

    // Rotate-left from 81 with one step every 8 clocks.
    applyStimulus(8'hC2, 8'h02);
    applyStimulus(8'hC0, 8'h81);
    applyStimulus(8'hC1, 8'h82);
    foreach (expQ[i]) ;
    expQ = '{32'h03, 32'h06, 32'h0C, 32'h18, 32'h30, 32'h60, 32'hC0, 32'h81};
    gapQ = '{0, 8, 8, 8, 8, 8, 8, 8};
    expectChanges("rot", 8, 40);

    // Bounce from 01: walk up, hold at 80, walk down, hold at 01, turn again.
    applyStimulus(8'hC1, 8'h00);
    applyStimulus(8'hC0, 8'h01);
    applyStimulus(8'hC1, 8'h83);
    expQ = '{32'h02, 32'h04, 32'h08, 32'h10, 32'h20, 32'h40, 32'h80,
             32'h40, 32'h20, 32'h10, 32'h08, 32'h04, 32'h02, 32'h01, 32'h02};
    gapQ = '{0, 8, 8, 8, 8, 8, 8, 16, 8, 8, 8, 8, 8, 8, 16};
    expectChanges("bnc", 15, 40);

    applyStimulus(8'hC1, 8'h00);
    applyStimulus(8'hC0, 8'hFF);
    applyStimulus(8'hC1, 8'h83);
    for (int i = 0; i < 20; i++) begin
      repeat (8) @(negedge CLK);
      expQ.push_back(32'hFF);
      popCompare("bnc_ff", LED);
    end

    // PWM duty on a static all-on idle pattern.
    applyStimulus(8'hC1, 8'h00);
    measureBright("pwm_b4", 4'h4, 4);
    measureBright("pwm_b0", 4'h0, 0);
    measureBright("pwm_bf", 4'hF, 16);

    // Blink with PERIOD=0 toggles on every tick.
    applyStimulus(8'hC2, 8'h00);
    applyStimulus(8'hC0, 8'h3C);
    applyStimulus(8'hC1, 8'h81);
    expQ = '{32'h00, 32'h3C, 32'h00, 32'h3C};
    gapQ = '{0, 4, 4, 4};
    expectChanges("blink", 4, 30);

    // Asynchronous reset while LED is lit.
    gap = 0;
    while (LED != 8'h3C && gap < 20) begin
      @(negedge CLK);
      gap++;
    end
    checkOutput("pre_rst_led", LED, 8'h3C);
    #2 RESET = 1'b1;
    #1 checkOutput("rst_async", LED, 8'h00);
    repeat (2) @(negedge CLK);
    checkOutput("rst_hold", LED, 8'h00);
    RESET = 1'b0;
    applyStimulus(8'hC2, 8'h01);
    applyStimulus(8'hC0, 8'h5A);
    waitChange(24, gap, timedOut);
    checkOutput("rst_ctrl_led", LED, 8'h5A);
    for (int i = 0; i < 3; i++) begin
      repeat (6) @(negedge CLK);
      expQ.push_back(32'h5A);
      popCompare("rst_ctrl_static", LED);
    end

    // Readback of PERIOD: bus driven only in the cycle after the read.
    applyStimulus(8'hC2, 8'h37);
    @(negedge CLK);
    checkOutput("rb_before", BUS_DATA, 8'h00);
    BUS_ADDR = 8'hC2;
    BUS_WE   = 1'b0;
    @(negedge CLK);
`ifdef LED_READBACK_EN
    expQ.push_back(32'h37);
`else
    expQ.push_back(32'h00);
`endif
    popCompare("rb_data", BUS_DATA);
    BUS_ADDR = 8'h00;
    @(negedge CLK);
    checkOutput("rb_after", BUS_DATA, 8'h00);
    @(negedge CLK);
    checkOutput("rb_idle", BUS_DATA, 8'h00);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
